// File: rtl/clock_div_multi_pkg.sv
// Shared constants and elaboration-time helpers for the multi-channel clock divider.
package clock_div_pkg;

  localparam int DEF_CLK_IN  = 25_000_000;
  localparam int DEF_CLK_OUT = 2;

  function automatic int half_def(input int clk_in, input int clk_out_def);
    return (clk_in / clk_out_def) / 2;
  endfunction

  function automatic int ch_idx_w(input int ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/clock_div_multi_if.sv
// Valid/ready configuration port: selects a channel and carries its new half-period.
interface clock_div_multi_if
  import clock_div_pkg::*;
#(
  parameter int CH = 4,
  parameter int W  = 24
);
  localparam int CHW = ch_idx_w(CH);

  logic           cfg_valid;
  logic           cfg_ready;
  logic [CHW-1:0] cfg_ch;
  logic [W-1:0]   cfg_half;

  modport master (output cfg_valid, output cfg_ch, output cfg_half, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_ch, input cfg_half, output cfg_ready);

endinterface

// File: rtl/clock_div_multi_ch.sv
// One divider channel: half-period counter, toggle, end-of-period tick and pending half-period slot.
// Optional lock indicator built only when CLOCK_DIV_LOCK_EN is defined.
module clock_div_ch #(
  parameter int             W        = 24,
  parameter logic [W-1:0]   HALF_DEF = W'(1)
) (
  input  logic         clk_in,
  input  logic         rst,
  input  logic         en,
  input  logic         sync,
  input  logic         wr_en,
  input  logic [W-1:0] wr_half,
  output logic         pend_valid,
  output logic         clk_out,
  output logic         tick
`ifdef CLOCK_DIV_LOCK_EN
  ,
  output logic         locked
`endif
);

  logic [W-1:0] cnt_q, cnt_d;
  logic [W-1:0] half_q, half_d;
  logic [W-1:0] pend_half_q, pend_half_d;
  logic         pend_valid_q, pend_valid_d;
  logic         clk_q, clk_d;
  logic         tick_q, tick_d;
  logic         frozen;
  logic         last;
  logic         apply;
`ifdef CLOCK_DIV_LOCK_EN
  logic         lock_q, lock_d;
`endif

  always_comb begin
    cnt_d        = cnt_q;
    half_d       = half_q;
    pend_half_d  = pend_half_q;
    pend_valid_d = pend_valid_q;
    clk_d        = clk_q;
    tick_d       = 1'b0;
    apply        = 1'b0;
    frozen       = ~en | (half_q == '0);
    last         = (cnt_q == half_q - W'(1));

    if (sync | frozen) begin
      cnt_d = '0;
      clk_d = 1'b0;
      apply = pend_valid_q;
    end else if (last) begin
      cnt_d  = '0;
      clk_d  = ~clk_q;
      // The 1->0 toggle closes a period: tick and swap in any pending half-period.
      tick_d = clk_q;
      apply  = pend_valid_q & clk_q;
    end else begin
      cnt_d = cnt_q + W'(1);
    end

    if (apply) begin
      half_d       = pend_half_q;
      pend_valid_d = 1'b0;
    end
    // Writes only arrive while the slot is empty, so they never collide with an apply.
    if (wr_en) begin
      pend_valid_d = 1'b1;
      pend_half_d  = wr_half;
    end
  end

`ifdef CLOCK_DIV_LOCK_EN
  always_comb begin
    lock_d = lock_q;
    if (sync | frozen | apply) lock_d = 1'b0;
    else if (tick_d)           lock_d = 1'b1;
  end
`endif

  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      half_q       <= HALF_DEF;
      pend_half_q  <= '0;
      pend_valid_q <= 1'b0;
      clk_q        <= 1'b0;
      tick_q       <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      half_q       <= half_d;
      pend_half_q  <= pend_half_d;
      pend_valid_q <= pend_valid_d;
      clk_q        <= clk_d;
      tick_q       <= tick_d;
    end
  end

`ifdef CLOCK_DIV_LOCK_EN
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) lock_q <= 1'b0;
    else     lock_q <= lock_d;
  end

  assign locked = lock_q;
`endif

  assign pend_valid = pend_valid_q;
  assign clk_out    = clk_q;
  assign tick       = tick_q;

endmodule

// File: rtl/clock_div_multi.sv
// N-channel programmable clock divider top: config decode, ready mux and sync fan-out.
// Optional per-channel lock output enabled by defining CLOCK_DIV_LOCK_EN.
module clock_div_multi
  import clock_div_pkg::*;
#(
  parameter int CLK_IN      = DEF_CLK_IN,
  parameter int CLK_OUT_DEF = DEF_CLK_OUT,
  parameter int CH          = 4,
  parameter int W           = 24
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [CH-1:0]     ch_en,
  input  logic              sync,
  clock_div_multi_if.slave  cfg,
  output logic [CH-1:0]     clk_out,
  output logic [CH-1:0]     tick
`ifdef CLOCK_DIV_LOCK_EN
  ,
  output logic [CH-1:0]     locked
`endif
);

  localparam int           CHW      = ch_idx_w(CH);
  localparam logic [W-1:0] HALF_DEF = W'(half_def(CLK_IN, CLK_OUT_DEF));

  logic [CH-1:0] pend_valid;
  logic [CH-1:0] wr_en;
  logic          cfg_ready;
  logic          cfg_fire;

  // Out-of-range channel indices stay ready so their writes are accepted and dropped.
  always_comb begin
    cfg_ready = 1'b1;
    for (int i = 0; i < CH; i++) begin
      if (cfg.cfg_ch == CHW'(i)) cfg_ready = ~pend_valid[i];
    end
  end

  assign cfg.cfg_ready = cfg_ready;
  assign cfg_fire      = cfg.cfg_valid & cfg_ready;

  for (genvar g = 0; g < CH; g++) begin : g_ch
    assign wr_en[g] = cfg_fire & (cfg.cfg_ch == CHW'(g));

    clock_div_ch #(
      .W        (W),
      .HALF_DEF (HALF_DEF)
    ) u_ch (
      .clk_in     (clk_in),
      .rst        (rst),
      .en         (ch_en[g]),
      .sync       (sync),
      .wr_en      (wr_en[g]),
      .wr_half    (cfg.cfg_half),
      .pend_valid (pend_valid[g]),
      .clk_out    (clk_out[g]),
      .tick       (tick[g])
`ifdef CLOCK_DIV_LOCK_EN
      ,
      .locked     (locked[g])
`endif
    );
  end

endmodule

// File: tb/tb_clock_div_multi.sv
// Self-checking bench for clock_div_multi: period-position reference model plus directed literal checks.
module tb_clock_div_multi;
  import clock_div_pkg::*;

  localparam int CLK_IN      = 100;
  localparam int CLK_OUT_DEF = 10;
  localparam int CH          = 5;
  localparam int W           = 24;
  localparam int CHW         = ch_idx_w(CH);
  localparam int HDEF        = (CLK_IN / CLK_OUT_DEF) / 2;

  logic          clk_in = 1'b0;
  logic          rst;
  logic [CH-1:0] ch_en;
  logic          sync;
  logic [CH-1:0] clk_out;
  logic [CH-1:0] tick;
`ifdef CLOCK_DIV_LOCK_EN
  logic [CH-1:0] locked;
`endif

  clock_div_multi_if #(.CH(CH), .W(W)) bus ();

  clock_div_multi #(
    .CLK_IN      (CLK_IN),
    .CLK_OUT_DEF (CLK_OUT_DEF),
    .CH          (CH),
    .W           (W)
  ) dut (
    .clk_in  (clk_in),
    .rst     (rst),
    .ch_en   (ch_en),
    .sync    (sync),
    .cfg     (bus),
    .clk_out (clk_out),
    .tick    (tick)
`ifdef CLOCK_DIV_LOCK_EN
    ,
    .locked  (locked)
`endif
  );

  always #5 clk_in = ~clk_in;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // Model: position k within the current output period; clk_out is high in the second half.
  int m_half [CH];
  int m_k    [CH];
  int m_ph   [CH];
  bit m_pv   [CH];
  bit m_clk  [CH];
  bit m_tick [CH];
  bit m_lock [CH];

  task automatic chk(input string name, input int act, input int exp);
    cmp_cnt++;
    if (act != exp) begin
      err_cnt++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic void m_reset();
    for (int c = 0; c < CH; c++) begin
      m_half[c] = HDEF; m_k[c] = 0; m_ph[c] = 0; m_pv[c] = 0;
      m_clk[c] = 0; m_tick[c] = 0; m_lock[c] = 0;
    end
  endfunction

  function automatic void m_step();
    int ch  = int'(bus.cfg_ch);
    bit acc = bus.cfg_valid && ((ch >= CH) || !m_pv[ch]);
    for (int c = 0; c < CH; c++) begin
      bit ap = 0;
      if (sync || !ch_en[c] || m_half[c] == 0) begin
        m_k[c] = 0; m_clk[c] = 0; m_tick[c] = 0; m_lock[c] = 0;
        ap = m_pv[c];
      end else begin
        m_k[c]++;
        m_tick[c] = (m_k[c] == 2 * m_half[c]);
        if (m_tick[c]) begin
          m_k[c]    = 0;
          ap        = m_pv[c];
          m_lock[c] = !m_pv[c];
        end
        m_clk[c] = (m_k[c] >= m_half[c]);
      end
      if (ap) begin
        m_half[c] = m_ph[c];
        m_pv[c]   = 0;
      end
      if (acc && ch == c) begin
        m_pv[c] = 1;
        m_ph[c] = int'(bus.cfg_half);
      end
    end
  endfunction

  always @(posedge clk_in) begin
    if (rst) m_reset();
    else     m_step();
    #1;
    if (!rst) begin
      for (int c = 0; c < CH; c++) begin
        chk($sformatf("clk_out[%0d]", c), int'(clk_out[c]), int'(m_clk[c]));
        chk($sformatf("tick[%0d]", c), int'(tick[c]), int'(m_tick[c]));
`ifdef CLOCK_DIV_LOCK_EN
        chk($sformatf("locked[%0d]", c), int'(locked[c]), int'(m_lock[c]));
`endif
      end
      chk("cfg_ready", int'(bus.cfg_ready),
          (int'(bus.cfg_ch) >= CH) ? 1 : int'(!m_pv[int'(bus.cfg_ch)]));
    end
  end

  task automatic cfg_write(input int ch, input int h, output int n);
    bit acc;
    n = 0;
    @(negedge clk_in);
    bus.cfg_valid = 1'b1;
    bus.cfg_ch    = CHW'(ch);
    bus.cfg_half  = W'(h);
    forever begin
      #1 acc = bus.cfg_ready;
      @(negedge clk_in);
      n++;
      if (acc) break;
      if (n > 100) begin
        chk("cfg_write_timeout", n, 0);
        break;
      end
    end
    bus.cfg_valid = 1'b0;
  endtask

  task automatic wait_rise(input int c, input int maxn, output int n);
    n = 0;
    forever begin
      @(posedge clk_in); #2;
      n++;
      if (clk_out[c]) break;
      if (n >= maxn) begin n = -1; break; end
    end
  endtask

  task automatic wait_tick(input int c, input int maxn, output int n);
    n = 0;
    forever begin
      @(posedge clk_in); #2;
      n++;
      if (tick[c]) break;
      if (n >= maxn) begin n = -1; break; end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, n2, hi;
    int first [CH];
    int exp_first [CH];

    rst = 1'b1;
    ch_en = '1;
    sync = 1'b0;
    bus.cfg_valid = 1'b0;
    bus.cfg_ch = '0;
    bus.cfg_half = '0;

    // Reset state and defaults
    repeat (3) @(negedge clk_in);
    chk("rst_clk_out", int'(clk_out), 0);
    chk("rst_tick", int'(tick), 0);
    chk("rst_ready", int'(bus.cfg_ready), 1);
    rst = 1'b0;
    wait_rise(0, 20, n);
    chk("default_first_rise", n, 5);
    wait_tick(0, 20, n);
    chk("default_first_tick", n, 5);

    // Runtime reprogram of ch1 mid-period
    repeat (3) @(posedge clk_in);
    cfg_write(1, 2, n);
    chk("reprog_latency", n, 1);
    wait_tick(1, 40, n);
    chk("reprog_apply_seen", int'(n > 0), 1);
    wait_tick(1, 20, n);
    chk("reprog_period", n, 4);

    // Back-pressure on ch0, ch2 unaffected
    cfg_write(0, 4, n);
    chk("bp_first", n, 1);
    cfg_write(2, 6, n);
    chk("bp_other_ch", n, 1);
    cfg_write(0, 5, n);
    chk("bp_second_held", int'(n > 1), 1);

    // Freeze ch3 with H=0, then restart with H=3
    cfg_write(3, 0, n);
    repeat (25) @(posedge clk_in);
    hi = 0;
    repeat (10) begin
      @(posedge clk_in); #2;
      hi = hi | int'(clk_out[3]) | int'(tick[3]);
    end
    chk("freeze_quiet", hi, 0);
    cfg_write(3, 3, n);
    wait_rise(3, 20, n);
    chk("unfreeze_first_rise", n, 4);

    // Sync re-alignment with a pending value on ch2
    cfg_write(0, 3, n);
    cfg_write(1, 7, n);
    repeat (12) @(posedge clk_in);
    cfg_write(2, 50, n);
    wait_tick(2, 40, n);
    chk("ch2_apply_seen", int'(n > 0), 1);
    cfg_write(2, 4, n);
    chk("ch2_pending_accept", n, 1);
    repeat ($urandom_range(6)) @(negedge clk_in);
    sync = 1'b1;
    @(negedge clk_in);
    sync = 1'b0;
    chk("sync_clears", int'(clk_out), 0);
    exp_first[0] = 3; exp_first[1] = 7; exp_first[2] = 4; exp_first[3] = 3; exp_first[4] = 5;
    for (int c = 0; c < CH; c++) first[c] = -1;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk_in); #2;
      for (int c = 0; c < CH; c++)
        if (first[c] < 0 && clk_out[c]) first[c] = k;
    end
    for (int c = 0; c < CH; c++)
      chk($sformatf("sync_first_rise[%0d]", c), first[c], exp_first[c]);

    // Randomized traffic against the model
    for (int i = 0; i < 800; i++) begin
      @(negedge clk_in);
      for (int c = 0; c < CH; c++) ch_en[c] = ($urandom_range(15) != 0);
      sync          = ($urandom_range(49) == 0);
      bus.cfg_valid = ($urandom_range(3) == 0);
      bus.cfg_ch    = CHW'($urandom_range(7));
      bus.cfg_half  = W'($urandom_range(9));
    end
    @(negedge clk_in);
    ch_en = '1;
    sync = 1'b0;
    bus.cfg_valid = 1'b0;
    repeat (7) @(negedge clk_in);

    // Async reset between edges
    #2 rst = 1'b1;
    #1;
    chk("arst_clk_out", int'(clk_out), 0);
    chk("arst_tick", int'(tick), 0);
    chk("arst_ready", int'(bus.cfg_ready), 1);
`ifdef CLOCK_DIV_LOCK_EN
    chk("arst_locked", int'(locked), 0);
`endif
    @(negedge clk_in);
    @(negedge clk_in);
    rst = 1'b0;
    wait_rise(0, 20, n);
    chk("arst_first_rise", n, HDEF);
    wait_tick(0, 20, n2);
    chk("arst_first_tick", n2, HDEF);
`ifdef CLOCK_DIV_LOCK_EN
    chk("lock_after_tick", int'(locked[0]), 1);
`endif

    repeat (5) @(posedge clk_in);
    #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/clock_div_multi.md
Name: clock_div_multi

Overview:
- N-channel programmable clock divider; successor of the fixed single-output divider.
- Each channel derives a 50% duty square wave plus a one-cycle period tick from clk_in.
- Half-period is runtime-programmable through a valid/ready config port; changes apply glitch-free at the period boundary.
- Global sync re-aligns all channel phases. Used for LED/pinout test strobes, UART/SPI bit enables and scan clocks on the board.

Parameters:
- CLK_IN, 25000000, input clock frequency in Hz.
- CLK_OUT_DEF, 2, reset-time output frequency in Hz for every channel.
- CH, 4, number of channels (1..16).
- W, 24, half-period counter width in bits.
- Localparam HALF_DEF = (CLK_IN/CLK_OUT_DEF)/2 (6250000 at defaults); must be < 2^W.

Ports:
- clk_in  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- ch_en  input  CH  per-channel run enable.
- sync  input  1  single-cycle phase-alignment strobe.
- cfg_valid  input  1  config request.
- cfg_ready  output  1  config accept.
- cfg_ch  input  $clog2(CH) (min 1)  target channel.
- cfg_half  input  W  new half-period in clk_in cycles.
- clk_out  output  CH  divided clocks.
- tick  output  CH  one-cycle pulse per completed output period.

Behaviour:
- Reset (async assert, release sync to clk_in):
  - per channel: cnt=0, clk_out=0, tick=0, active half = HALF_DEF, pending empty.
  - cfg_ready=1.
- Channel run (ch_en=1, active half H≥1):
  - cnt counts 0..H-1.
  - At cnt==H-1: clk_out toggles and cnt returns to 0.
  - Period = 2H clk_in cycles.
  - H=1 gives clk_in/2.
- tick: asserted, registered, in the same cycle clk_out goes 1→0 (end of period). One cycle wide.
- H=0: channel frozen; cnt=0, clk_out=0, tick=0.
- ch_en=0: same as H=0 (cnt, clk_out, tick forced 0 next cycle). On re-enable, counting starts from 0 with clk_out=0.
- Config handshake:
  - cfg_ready = ~pending_valid[cfg_ch] (combinational from registered state).
  - Transfer when cfg_valid & cfg_ready: cfg_half is stored in that channel's pending register.
  - cfg_ch ≥ CH: transfer accepted and discarded.
- Pending apply: at the next end-of-period event (the cycle clk_out goes 1→0).
  - New H is used from the following cycle.
  - cnt=0 at that point, so there are no runt pulses.
  - If the channel is frozen (H=0 or ch_en=0), pending applies on the next cycle.
  - The pending slot clears in the apply cycle, so ready reasserts the cycle after.
- sync=1, highest priority after reset:
  - every channel: cnt=0, clk_out=0, tick=0.
  - any pending value is applied immediately.
  - A cfg transfer in the same cycle lands in pending (slot now free next cycle); the pending value is applied and the new one waits.
- Simultaneous end-of-period and config write to the same channel: not possible, because ready is low while pending is held.
- Counter arithmetic is unsigned, W bits. There is no wrap beyond H-1 because compare is equality and H ≤ 2^W-1.
- Latency: clk_out and tick are registered. The first toggle after enable is H cycles after ch_en rises.

Optional Feature:
- Macro CLOCK_DIV_LOCK_EN.
- Defined: adds output `locked` (CH bits).
  - Cleared on reset, on sync, on config apply, and on ch_en=0 or H=0.
  - Set in the cycle tick first fires thereafter; stays set until the next clear event.
- Undefined: port absent, no extra logic.

Decomposition:
- Package clock_div_pkg holds:
  - default CLK_IN/CLK_OUT_DEF constants;
  - the HALF_DEF computation function;
  - the channel-index width function (max(1,$clog2(CH))).
- One sub-module, clock_div_ch:
  - contains the per-channel counter, toggle, tick, pending register and apply logic (and lock bit);
  - instantiated CH times in a generate loop.
- The top holds only the cfg decode/ready mux and sync fan-out.

Test Plan:
- Reset defaults: CLK_IN=100, CLK_OUT_DEF=10, ch_en=all 1 → every clk_out toggles every 5 cycles; tick every 10 cycles; outputs 0 during rst.
- Runtime reprogram: ch1 running H=5, write cfg_half=2 mid-period → old period completes; after clk_out 1→0, period=4; cfg_ready low from accept until apply+1.
- Back-pressure: two back-to-back writes to ch0 → second held (cfg_ready=0) until first applies; write to ch2 in the same window accepted immediately.
- Freeze: write H=0 to ch3 → after boundary clk_out[3]=0, tick[3]=0; write H=3 → period 6 starts next cycle from cnt=0.
- Sync: channels at H=3 and H=7 with random phase, pulse sync → both clk_out=0 next cycle; first toggles at +3 and +7 cycles; pending value applied at sync.
- Async reset mid-period (rst asserted between edges) → outputs 0 immediately; after release, counting restarts with HALF_DEF and empty pending (with CLOCK_DIV_LOCK_EN: locked=0 until the first tick).
